// File: rtl/call_stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : call_stack_pkg
// Brief   : Shared defaults, operation encoding and count-width helper for
//           the call stack.
// Rev     : 1.0
// ============================================================================
package call_stack_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 8;
    localparam int unsigned c_DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } op_e;

    // One extra bit beyond the address so that a full stack (count == DEPTH)
    // can be represented.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// ============================================================================
// Module  : stack_ram
// Brief   : DEPTH x WIDTH register array, synchronous write, async read.
// Rev     : 1.0
// ============================================================================
module stack_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
// Module  : call_stack
// Brief   : Hardware return-address stack with registered top-of-stack,
//           count, and sticky overflow/underflow flags.
// Rev     : 1.0
// ============================================================================
module call_stack
    import call_stack_pkg::*;
#(
    parameter int unsigned WIDTH = c_DEFAULT_WIDTH,
    parameter int unsigned DEPTH = c_DEFAULT_DEPTH,
    localparam int unsigned PW   = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] out,
    output logic [PW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned   AW     = $clog2(DEPTH);
    localparam logic [PW-1:0] c_FULL = PW'(DEPTH);
    localparam logic [PW-1:0] c_ONE  = PW'(1);
    localparam logic [PW-1:0] c_TWO  = PW'(2);

    // Initialisers make the power-up state identical to the reset state.
    logic [PW-1:0]    r_count     = '0;
    logic [WIDTH-1:0] r_out       = '0;
    logic             r_overflow  = 1'b0;
    logic             r_underflow = 1'b0;

    op_e              w_op;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [AW-1:0]    w_raddr;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);

    always_comb begin
        w_op = OP_IDLE;
        if (push && pop) begin
            w_op = OP_REPL;
        end else if (push) begin
            w_op = OP_PUSH;
        end else if (pop) begin
            w_op = OP_POP;
        end
    end

    // Replace on an empty stack degenerates to a push into slot 0.
    assign w_we    = (w_op == OP_REPL) || ((w_op == OP_PUSH) && !w_full);
    assign w_waddr = ((w_op == OP_REPL) && !w_empty) ? AW'(r_count - c_ONE)
                                                     : AW'(r_count);
    // Entry just below the current top; only consumed when count >= 2.
    assign w_raddr = AW'(r_count - c_TWO);

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack_ram (
        .clk     (clk),
        .i_we    (w_we && !reset),
        .i_waddr (w_waddr),
        .i_wdata (in),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_out       <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (w_op)
                OP_REPL: begin
                    r_out <= in;
                    if (w_empty) begin
                        r_count     <= c_ONE;
                        r_underflow <= 1'b1;
                    end
                end
                OP_PUSH: begin
                    if (w_full) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + c_ONE;
                        r_out   <= in;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        r_underflow <= 1'b1;
                    end else begin
                        r_count <= r_count - c_ONE;
                        r_out   <= (r_count == c_ONE) ? '0 : w_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out       = r_out;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_call_stack.sv
`default_nettype none
// ============================================================================
// Module  : tb_call_stack
// Brief   : Self-checking bench for call_stack: directed scenarios plus a
//           randomised run against a queue-based reference model.
// Rev     : 1.0
// ============================================================================
module tb_call_stack;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PW    = $clog2(DEPTH) + 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic [WIDTH-1:0] in    = '0;
    logic             push  = 1'b0;
    logic             pop   = 1'b0;
    logic [WIDTH-1:0] out;
    logic [PW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    int n_vec = 0;
    int n_bad = 0;

    call_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .push      (push),
        .pop       (pop),
        .out       (out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue, top of stack at the back.
    logic [WIDTH-1:0] m_q[$];
    bit               m_of = 1'b0;
    bit               m_uf = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_of = 1'b0;
            m_uf = 1'b0;
        end else if (push && pop) begin
            if (m_q.size() == 0) begin
                m_q.push_back(in);
                m_uf = 1'b1;
            end else begin
                m_q[m_q.size()-1] = in;
            end
        end else if (push) begin
            if (m_q.size() == DEPTH) m_of = 1'b1;
            else                     m_q.push_back(in);
        end else if (pop) begin
            if (m_q.size() == 0) m_uf = 1'b1;
            else                 void'(m_q.pop_back());
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e_out;
        int               sz;
        sz    = m_q.size();
        e_out = (sz == 0) ? '0 : m_q[sz-1];
        chk("cyc out",       32'(out),       32'(e_out));
        chk("cyc count",     32'(count),     32'(sz));
        chk("cyc empty",     32'(empty),     32'(sz == 0));
        chk("cyc full",      32'(full),      32'(sz == DEPTH));
        chk("cyc overflow",  32'(overflow),  32'(m_of));
        chk("cyc underflow", 32'(underflow), 32'(m_uf));
    end

    task automatic step(input logic r, input logic pu, input logic po, input logic [WIDTH-1:0] d);
        @(negedge clk);
        reset = r;
        push  = pu;
        pop   = po;
        in    = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hi_push;
        logic [WIDTH-1:0] v;

        // Power-up state equals reset state.
        #1;
        chk("pwrup count", 32'(count), 32'd0);
        chk("pwrup empty", 32'(empty), 32'd1);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("rst count", 32'(count), 32'd0);
        chk("rst out",   32'(out),   32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full",  32'(full),  32'd0);
        chk("rst flags", 32'({overflow, underflow}), 32'd0);

        step(1'b0, 1'b1, 1'b0, 8'h12);
        step(1'b0, 1'b1, 1'b0, 8'h34);
        step(1'b0, 1'b1, 1'b0, 8'h56);
        chk("p3 out",   32'(out),   32'h56);
        chk("p3 count", 32'(count), 32'd3);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop1 out", 32'(out), 32'h34);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("pop2 out", 32'(out), 32'h12);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        chk("fill full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'hFF);
        chk("ovf flag",  32'(overflow), 32'd1);
        chk("ovf out",   32'(out),      32'h08);
        chk("ovf count", 32'(count),    32'd8);
        step(1'b0, 1'b1, 1'b1, 8'hAB);
        chk("full repl out",  32'(out),   32'hAB);
        chk("full repl count", 32'(count), 32'd8);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("udf flag",  32'(underflow), 32'd1);
        chk("udf out",   32'(out),       32'd0);
        chk("udf count", 32'(count),     32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h20);
        chk("udf push out", 32'(out),       32'h20);
        chk("udf sticky",   32'(underflow), 32'd1);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h44);
        chk("empty repl count", 32'(count),     32'd1);
        chk("empty repl uf",    32'(underflow), 32'd1);
        chk("empty repl out",   32'(out),       32'h44);

        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h10);
        step(1'b0, 1'b1, 1'b0, 8'h20);
        step(1'b0, 1'b1, 1'b1, 8'h99);
        chk("repl count", 32'(count), 32'd2);
        chk("repl out",   32'(out),   32'h99);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("repl pop out", 32'(out), 32'h10);

        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 8'h02);
        step(1'b0, 1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("rstpush count", 32'(count), 32'd0);
        chk("rstpush out",   32'(out),   32'd0);
        chk("rstpush empty", 32'(empty), 32'd1);
        chk("rstpush flags", 32'({overflow, underflow}), 32'd0);

        // Randomised run; push bias changes per block to reach both ends.
        hi_push = 50;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) hi_push = 20 + 30 * ((c / 150) % 3);
            v = 8'($urandom);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < 30 + hi_push / 2),
                 ($urandom_range(0, 99) < 75 - hi_push / 2),
                 v);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/call_stack.md
CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each stacked word, such as a program-counter value.
REQ-002 Parameter DEPTH, default 8: number of entries; SHALL be a power of two between 2 and 256.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in  input  WIDTH: word to push, for example the return address.
REQ-006 push  input  1: push request.
REQ-007 pop  input  1: pop request.
REQ-008 out  output  WIDTH: registered top-of-stack word; 0 when empty.
REQ-009 count  output  clog2(DEPTH)+1: registered number of valid entries.
REQ-010 empty  output  1: high when count == 0.
REQ-011 full  output  1: high when count == DEPTH.
REQ-012 overflow  output  1: sticky flag; push rejected while full.
REQ-013 underflow  output  1: sticky flag; pop rejected while empty.

Function
REQ-014 Push only, not full: store in at index count, increment count, and show out = in from the next edge.
REQ-015 Pop only, not empty: decrement count; out becomes the entry below the old top, or 0 if the stack becomes empty.
REQ-016 Push and pop together, not empty: replace the top entry with in; count is unchanged; out = in from the next edge.
REQ-017 Push and pop together, empty: treat as push only; set underflow; count becomes 1; out = in.
REQ-018 Push only while full: do not change storage, count or out; set overflow.
REQ-019 Pop only while empty: do not change count or out; out stays 0; set underflow.
REQ-020 Push and pop together while full: perform the replace of REQ-016; do not set overflow.
REQ-021 Neither push nor pop: hold all state.
REQ-022 count SHALL never exceed DEPTH or wrap below 0.
REQ-023 overflow and underflow stay set until reset; only reset clears them.
REQ-024 empty and full are derived from the registered count, with no combinational path from push, pop or in.
REQ-025 Every operation completes in one cycle; out and count are valid on the edge that performs the operation; there is no stall or backpressure.

Reset
REQ-026 On reset: count = 0, out = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
REQ-027 Reset takes priority over push and pop in the same cycle.
REQ-028 Storage contents need not be cleared; they are unobservable after reset.
REQ-029 Reset asserted while operations are in progress discards all entries on that edge.
REQ-030 Initial power-up state SHALL equal the reset state.

Structure
REQ-031 A shared package holds the default WIDTH and DEPTH constants and the pointer-width function clog2(DEPTH)+1.
REQ-032 Storage is a sub-module named stack_ram: DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port.
REQ-033 The sub-module holds no reset logic.
REQ-034 call_stack holds the count register, the out register, the error flags and all push/pop decision logic.

Verification
REQ-035 Reset, then push 0x12, 0x34, 0x56 -> out = 0x56, count = 3; pop, pop -> out = 0x34, then 0x12.
REQ-036 With DEPTH = 8, push 0x01..0x08 -> full = 1; push 0xFF -> overflow = 1, out = 0x08, count = 8.
REQ-037 Pop while empty -> underflow = 1, out = 0, count = 0; a following push 0x20 -> out = 0x20 and underflow stays 1.
REQ-038 With stack [0x10, 0x20], push and pop 0x99 together -> count = 2, out = 0x99; pop -> out = 0x10.
REQ-039 Assert reset together with push 0x77 on a 3-deep stack -> count = 0, out = 0, empty = 1, flags cleared.
REQ-040 Random push/pop sequence of at least 1000 cycles against a reference model -> out, count, empty, full and flags match every cycle.
